// File: rtl/seq_burst_scheduler.sv
// Round-robin burst scheduler that shares one sequence generator between requesters.
// Each granted burst streams req_len+1 generator values to a single tagged valid/ready output.
module seq_burst_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 4,
  parameter int DATA_W  = 4,
  parameter int ID_W    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     abort,
  output logic                     gen_enable,
  input  logic [DATA_W-1:0]        gen_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     burst_done,
  output logic                     burst_aborted,
  output logic                     busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   next_ptr;
  logic               found;
  logic [LEN_W-1:0]   count;
  logic [ID_W-1:0]    id_q;
  logic               aborted_q;
  logic               accept;
  int                 idx;

  // Search upward from rr_ptr with wrap; the first requester found wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  assign next_ptr      = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign accept        = (state == BURST) && out_ready;
  assign out_valid     = (state == BURST);
  assign gen_enable    = accept;
  assign out_data      = out_valid ? gen_data : '0;
  assign out_id        = id_q;
  assign burst_done    = (state == DONE);
  assign burst_aborted = burst_done && aborted_q;
  assign busy          = (state != IDLE);
  // Gated by reset so a request held across reset never shows a grant.
  assign req_ready     = (state == IDLE && found && !reset) ? (NUM_REQ'(1) << winner) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      count     <= '0;
      id_q      <= '0;
      aborted_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          aborted_q <= 1'b0;
          if (found) begin
            count  <= req_len[winner*LEN_W +: LEN_W];
            id_q   <= ID_W'(winner);
            rr_ptr <= next_ptr;
            state  <= BURST;
          end
        end
        BURST: begin
          // A final beat taken together with abort is a normal completion.
          if (accept && count == '0) begin
            state     <= DONE;
            aborted_q <= 1'b0;
          end else begin
            if (accept) count <= count - 1'b1;
            if (abort) begin
              state     <= DONE;
              aborted_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          aborted_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_burst_scheduler.sv
// Bench for seq_burst_scheduler: models the shared generator, keeps a burst-level reference
// model compared every cycle, and pins the model with literal beat/grant/done expectations.
module tb_seq_burst_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req_valid;
  logic [7:0] req_len;
  logic [1:0] req_ready;
  logic       abort;
  logic       gen_enable;
  logic [3:0] gen_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [0:0] out_id;
  logic       burst_done;
  logic       burst_aborted;
  logic       busy;
  logic       gen_clear;

  int checks = 0;
  int passed = 0;

  seq_burst_scheduler #(.NUM_REQ(2), .LEN_W(4), .DATA_W(4), .ID_W(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_len(req_len),
    .req_ready(req_ready), .abort(abort), .gen_enable(gen_enable), .gen_data(gen_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .burst_done(burst_done), .burst_aborted(burst_aborted), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] seq_val(int i);
    case (i % 8)
      0: return 4'hA;
      1: return 4'hB;
      2: return 4'hE;
      3: return 4'h7;
      4: return 4'hF;
      5: return 4'h2;
      6: return 4'h0;
      default: return 4'hD;
    endcase
  endfunction

  // Shared generator: advances only on gen_enable, never reset by the scheduler.
  int gen_pos = 0;
  always @(posedge clk) begin
    if (gen_clear) gen_pos <= 0;
    else if (gen_enable) gen_pos <= (gen_pos + 1) % 8;
  end
  assign gen_data = seq_val(gen_pos);

  function automatic int pick(int rr, logic [1:0] rv);
    for (int k = 0; k < 2; k++) begin
      if (rv[(rr + k) % 2]) return (rr + k) % 2;
    end
    return -1;
  endfunction

  // Burst-level reference: phase 0 idle, 1 streaming, 2 done; beats counted as remaining beats.
  int m_phase = 0, m_left = 0, m_id = 0, m_rr = 0, m_pos = 0, m_w = 0;
  bit m_ab = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (gen_clear) m_pos = 0;
    if (reset) begin
      m_phase = 0; m_left = 0; m_id = 0; m_rr = 0; m_ab = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_w = pick(m_rr, req_valid);
          if (m_w >= 0) begin
            m_left  = int'(req_len[m_w*4 +: 4]) + 1;
            m_id    = m_w;
            m_rr    = (m_w + 1) % 2;
            m_phase = 1;
          end
        end
        1: begin
          if (out_ready) begin
            m_pos  = (m_pos + 1) % 8;
            m_left = m_left - 1;
          end
          if (out_ready && m_left == 0) begin
            m_phase = 2; m_ab = 1'b0;
          end else if (abort) begin
            m_phase = 2; m_ab = 1'b1;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic check_output(string name, int actual, int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  logic [7:0] acc_q[$];
  logic [1:0] grant_q[$];
  bit         done_q[$];
  int         en_cnt = 0;

  int e_rdy, e_valid, e_en, e_data, e_done, e_ab, e_busy, e_w;
  always @(negedge clk) begin
    e_rdy = 0; e_valid = 0; e_en = 0; e_data = 0; e_done = 0; e_ab = 0; e_busy = 0;
    if (!reset) begin
      case (m_phase)
        0: begin
          e_w = pick(m_rr, req_valid);
          if (e_w >= 0) e_rdy = 1 << e_w;
        end
        1: begin
          e_valid = 1; e_data = int'(seq_val(m_pos)); e_en = int'(out_ready); e_busy = 1;
        end
        default: begin
          e_done = 1; e_ab = int'(m_ab); e_busy = 1;
        end
      endcase
    end
    check_output("req_ready", int'(req_ready), e_rdy);
    check_output("out_valid", int'(out_valid), e_valid);
    check_output("gen_enable", int'(gen_enable), e_en);
    check_output("out_data", int'(out_data), e_data);
    check_output("out_id", int'(out_id), reset ? 0 : m_id);
    check_output("burst_done", int'(burst_done), e_done);
    check_output("burst_aborted", int'(burst_aborted), e_ab);
    check_output("busy", int'(busy), e_busy);
    if (out_valid && out_ready) acc_q.push_back({3'b000, out_id, out_data});
    if (req_ready != 2'b00) grant_q.push_back(req_ready);
    if (gen_enable) en_cnt++;
    if (burst_done) done_q.push_back(burst_aborted);
  end

  task automatic clear_logs();
    acc_q.delete(); grant_q.delete(); done_q.delete(); en_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; gen_clear = 1'b1;
    req_valid = 2'b00; abort = 1'b0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; gen_clear = 1'b0;
    clear_logs();
  endtask

  task automatic apply_stimulus(int id, int len);
    req_len = 8'h00;
    req_len[id*4 +: 4] = 4'(len);
    req_valid = 2'b00;
    req_valid[id] = 1'b1;
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  task automatic wait_done(int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (burst_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("done_within_budget", int'(seen), 1);
    @(posedge clk); #1;
  endtask

  task automatic check_log(string name, int idx, int expected);
    if (idx < acc_q.size()) check_output(name, int'(acc_q[idx]), expected);
    else check_output(name, -1, expected);
  endtask

  task automatic check_done(string name, int idx, int expected);
    if (idx < done_q.size()) check_output(name, int'(done_q[idx]), expected);
    else check_output(name, -1, expected);
  endtask

  logic [3:0] t4_exp[10] = '{4'hA, 4'hB, 4'hE, 4'h7, 4'hF, 4'h2, 4'h0, 4'hD, 4'hA, 4'hB};
  bit         t3_ready[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    req_valid = 2'b00; req_len = 8'h00; abort = 1'b0; out_ready = 1'b1; gen_clear = 1'b0;
    #1;
    do_reset();

    // Single burst of three beats from requester 0.
    check_output("reset_busy", int'(busy), 0);
    apply_stimulus(0, 2);
    wait_done(20);
    check_log("t1_beat0", 0, 8'h0A);
    check_log("t1_beat1", 1, 8'h0B);
    check_log("t1_beat2", 2, 8'h0E);
    check_output("t1_beats", acc_q.size(), 3);
    check_output("t1_enables", en_cnt, 3);
    check_done("t1_aborted", 0, 0);
    check_output("t1_busy_after", int'(busy), 0);

    // Both requesters held, zero-length bursts alternate.
    do_reset();
    req_len = 8'h00; req_valid = 2'b11;
    repeat (7) @(posedge clk);
    #1 req_valid = 2'b00;
    wait_done(10);
    check_log("t2_grant0", 0, 8'h0A);
    check_log("t2_grant1", 1, 8'h1B);
    check_log("t2_grant2", 2, 8'h0E);
    check_output("t2_grants", grant_q.size(), 3);
    if (grant_q.size() == 3) begin
      check_output("t2_ready0", int'(grant_q[0]), 1);
      check_output("t2_ready1", int'(grant_q[1]), 2);
      check_output("t2_ready2", int'(grant_q[2]), 1);
    end

    // Backpressure holds the current value without skipping or repeating.
    do_reset();
    apply_stimulus(0, 3);
    for (int i = 1; i < 6; i++) begin
      @(posedge clk); #1;
      out_ready = t3_ready[i];
      if (!t3_ready[i]) begin
        #1;
        check_output("t3_stall_data", int'(out_data), 4'hB);
        check_output("t3_stall_enable", int'(gen_enable), 0);
      end
    end
    wait_done(10);
    check_log("t3_beat0", 0, 8'h0A);
    check_log("t3_beat1", 1, 8'h0B);
    check_log("t3_beat2", 2, 8'h0E);
    check_log("t3_beat3", 3, 8'h07);
    check_output("t3_enables", en_cnt, 4);

    // Ten beats wrap the eight-value sequence.
    do_reset();
    apply_stimulus(0, 9);
    wait_done(20);
    check_output("t4_beats", acc_q.size(), 10);
    for (int i = 0; i < 10; i++) check_log("t4_beat", i, int'(t4_exp[i]));

    // Abort on the second accepted beat; generator position carries to the next burst.
    do_reset();
    apply_stimulus(0, 5);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done(5);
    check_output("t5_beats", acc_q.size(), 2);
    check_log("t5_beat1", 1, 8'h0B);
    check_done("t5_aborted", 0, 1);
    apply_stimulus(1, 0);
    wait_done(10);
    check_log("t5_next", 2, 8'h1E);
    check_done("t5_next_aborted", 1, 0);

    // Reset during the third beat drops the burst with no done pulse.
    do_reset();
    apply_stimulus(0, 5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 2'b01;
    reset = 1'b1;
    #1;
    check_output("t6_valid", int'(out_valid), 0);
    check_output("t6_busy", int'(busy), 0);
    check_output("t6_ready", int'(req_ready), 0);
    check_output("t6_enable", int'(gen_enable), 0);
    check_output("t6_data", int'(out_data), 0);
    check_output("t6_no_done", done_q.size(), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 req_valid = 2'b00;
    wait_done(20);
    check_output("t6_grants", grant_q.size(), 2);
    if (grant_q.size() == 2) check_output("t6_regrant", int'(grant_q[1]), 1);
    check_log("t6_resume", 2, 8'h0E);
    check_output("t6_beats", acc_q.size(), 8);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
